// File: rtl/pixel_pkg.sv
// Shared pixel FIFO word layout and reader FSM state encoding.
// The color-transform write side packs words with the same field offsets.
package pixel_pkg;

  localparam int PIX_W      = 44;
  localparam int COORD_W    = 10;
  localparam int RGB_W      = 24;
  localparam int X_MSB      = 43;
  localparam int X_LSB      = 34;
  localparam int Y_MSB      = 33;
  localparam int Y_LSB      = 24;
  localparam int RED_MSB    = 23;
  localparam int RED_LSB    = 16;
  localparam int GREEN_MSB  = 15;
  localparam int GREEN_LSB  = 8;
  localparam int BLUE_MSB   = 7;
  localparam int BLUE_LSB   = 0;

  localparam int H_RES_DEF  = 640;
  localparam int V_RES_DEF  = 480;
  localparam int ADDR_W_DEF = 19;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  function automatic logic [COORD_W-1:0] pix_x(input logic [PIX_W-1:0] w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic logic [COORD_W-1:0] pix_y(input logic [PIX_W-1:0] w);
    return w[Y_MSB:Y_LSB];
  endfunction

  function automatic logic [RGB_W-1:0] pix_rgb(input logic [PIX_W-1:0] w);
    return {w[RED_MSB:RED_LSB], w[GREEN_MSB:GREEN_LSB], w[BLUE_MSB:BLUE_LSB]};
  endfunction

endpackage

// File: rtl/pixel_fifo_reader_if.sv
// FIFO read port plus frame-buffer write port of the pixel FIFO reader.
// master = the reader, slave = the FIFO/memory-controller environment.
interface pixel_fifo_reader_if
  import pixel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              rdempty;
  logic [PIX_W-1:0]  q_i;
  logic              rdreq;
  logic              rdclk_25;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [RGB_W-1:0]  mem_data_o;
  logic              mem_ack_i;

  modport master (
    input  rdempty, q_i, mem_ack_i,
    output rdreq, rdclk_25, mem_wr_o, mem_addr_o, mem_data_o
  );

  modport slave (
    output rdempty, q_i, mem_ack_i,
    input  rdreq, rdclk_25, mem_wr_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/pixel_fifo_reader_fb_addr_calc.sv
// Combinational linear frame-buffer address y*H_RES + x with on-screen check.
module fb_addr_calc
  import pixel_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_range
);

  generate
    if (H_RES == 640) begin : g_shift
      // 640 = 512 + 128, so the stride multiply reduces to two shifts and adds
      always_comb begin
        addr = (ADDR_W'(y) << 4'd9) + (ADDR_W'(y) << 4'd7) + ADDR_W'(x);
      end
    end else begin : g_mult
      // Generic stride multiply for other line lengths
      always_comb begin
        addr = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
      end
    end
  endgenerate

  // Coordinates compared at 32 bits so any H_RES/V_RES value is honoured
  always_comb begin
    in_range = (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));
  end

endmodule

// File: rtl/pixel_fifo_reader.sv
// Pops packed pixels from the pixel FIFO and writes them to the frame buffer.
// Optional macro PIXEL_DROP_CNT_EN adds a saturating dropped-pixel counter drop_cnt_o.
module pixel_fifo_reader
  import pixel_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)
(
  input  logic                clk_25,
  input  logic                reset,
  pixel_fifo_reader_if.master bus
`ifdef PIXEL_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt_o
`endif
);

  state_t            state_r, state_s;
  logic              rdreq_r, rdreq_s;
  logic              mem_wr_r, mem_wr_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [RGB_W-1:0]  mem_data_r, mem_data_s;
  logic [ADDR_W-1:0] calc_addr_s;
  logic              in_range_s;

  fb_addr_calc #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .x        (pix_x(bus.q_i)),
    .y        (pix_y(bus.q_i)),
    .addr     (calc_addr_s),
    .in_range (in_range_s)
  );

  // Next-state and next-output logic; outputs hold unless a state changes them
  always_comb begin
    state_s    = state_r;
    rdreq_s    = 1'b0;
    mem_wr_s   = mem_wr_r;
    mem_addr_s = mem_addr_r;
    mem_data_s = mem_data_r;
    case (state_r)
      S_IDLE: begin
        if (!bus.rdempty) begin
          rdreq_s = 1'b1;
          state_s = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        state_s = S_LATCH;
      end
      S_LATCH: begin
        if (in_range_s) begin
          mem_addr_s = calc_addr_s;
          mem_data_s = pix_rgb(bus.q_i);
          mem_wr_s   = 1'b1;
          state_s    = S_WRITE;
        end else begin
          mem_wr_s = 1'b0;
          state_s  = S_IDLE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack_i) begin
          mem_wr_s = 1'b0;
          state_s  = S_IDLE;
        end else begin
          state_s = S_WRITE;
        end
      end
      default: begin
        mem_wr_s = 1'b0;
        state_s  = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset cancels any pending write at once
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      rdreq_r    <= 1'b0;
      mem_wr_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
    end else begin
      state_r    <= state_s;
      rdreq_r    <= rdreq_s;
      mem_wr_r   <= mem_wr_s;
      mem_addr_r <= mem_addr_s;
      mem_data_r <= mem_data_s;
    end
  end

  assign bus.rdreq      = rdreq_r;
  assign bus.rdclk_25   = clk_25;
  assign bus.mem_wr_o   = mem_wr_r;
  assign bus.mem_addr_o = mem_addr_r;
  assign bus.mem_data_o = mem_data_r;

`ifdef PIXEL_DROP_CNT_EN
  logic [15:0] drop_cnt_r;
  logic        drop_hit_s;

  assign drop_hit_s = (state_r == S_LATCH) && !in_range_s;

  // Saturating count of off-screen pixels discarded in S_LATCH
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_hit_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_pixel_fifo_reader.sv
// Self-checking bench for pixel_fifo_reader: FIFO and memory-controller models,
// a queue-based reference of expected frame-buffer writes, and directed plus random steps.
module tb_pixel_fifo_reader;

  localparam int H = 640;
  localparam int V = 480;

  logic clk_25;
  logic reset;

  pixel_fifo_reader_if #(.ADDR_W(19)) bus ();

`ifdef PIXEL_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  pixel_fifo_reader #(.H_RES(H), .V_RES(V), .ADDR_W(19)) dut (
    .clk_25 (clk_25),
    .reset  (reset),
    .bus    (bus.master)
`ifdef PIXEL_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  int n_assert = 0;
  int n_fail   = 0;

  logic [43:0] fifo_q[$];
  logic [42:0] exp_q[$];
  logic [42:0] obs_q[$];
  int          lat_q[$];
  int          len_q[$];
  int          exp_drop  = 0;
  int          underflow = 0;
  int          viol      = 0;
  int          rd_cnt    = 0;
  int          cyc       = 0;

  bit ack_tied  = 1'b0;
  bit ack_rand  = 1'b0;
  int ack_delay = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: word appears on q_i the cycle after rdreq is sampled
  initial begin
    bit took;
    bus.rdempty = 1'b1;
    bus.q_i     = '0;
    forever begin
      @(negedge clk_25);
      took = bus.rdreq;
      @(posedge clk_25);
      #1;
      if (took) begin
        if (fifo_q.size() == 0) underflow++;
        else bus.q_i = fifo_q.pop_front();
      end
      bus.rdempty = (fifo_q.size() == 0);
    end
  end

  // Memory controller model: ack after a configurable number of wait cycles
  initial begin
    int wcnt;
    int cur_delay;
    wcnt = 0;
    cur_delay = 0;
    bus.mem_ack_i = 1'b0;
    forever begin
      @(posedge clk_25);
      #1;
      if (!bus.mem_wr_o) wcnt = 0;
      else if (wcnt == 0) cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
      bus.mem_ack_i = ack_tied || (bus.mem_wr_o && (wcnt >= cur_delay));
      if (bus.mem_wr_o) wcnt++;
    end
  end

  // Monitor: records completed writes, latency, pulse widths and protocol breaches
  initial begin
    bit prev_wr, prev_rd;
    int last_rd_cyc, wr_len;
    logic [42:0] cur;
    prev_wr = 0; prev_rd = 0; last_rd_cyc = 0; wr_len = 0; cur = '0;
    forever begin
      @(negedge clk_25);
      cyc++;
      if (!reset) begin
        prev_wr = 0;
        prev_rd = 0;
      end else begin
        if (bus.rdreq) begin
          rd_cnt++;
          last_rd_cyc = cyc;
          if (prev_rd || bus.mem_wr_o) viol++;
        end
        if (bus.mem_wr_o && !prev_wr) begin
          cur = {bus.mem_addr_o, bus.mem_data_o};
          wr_len = 0;
          lat_q.push_back(cyc - last_rd_cyc);
        end
        if (bus.mem_wr_o) begin
          wr_len++;
          if ({bus.mem_addr_o, bus.mem_data_o} !== cur) viol++;
          if (bus.mem_ack_i) begin
            obs_q.push_back({bus.mem_addr_o, bus.mem_data_o});
            len_q.push_back(wr_len);
          end
        end
        prev_wr = bus.mem_wr_o;
        prev_rd = bus.rdreq;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25);
    #1;
  endtask

  task automatic push_pix(input int x, input int y, input logic [23:0] rgb);
    logic [43:0] w;
    w = {10'(x), 10'(y), rgb};
    fifo_q.push_back(w);
    if (x < H && y < V) exp_q.push_back({19'(y * H + x), rgb});
    else exp_drop++;
  endtask

  task automatic wait_obs(input int n);
    int budget;
    budget = 500;
    while (obs_q.size() < n && budget > 0) begin
      tick(1);
      budget--;
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 3000;
    while ((fifo_q.size() != 0 || obs_q.size() < exp_q.size()) && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(6);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    while (lat_q.size() > 0) chk({tag, "_latency"}, lat_q.pop_front(), 2);
  endtask

  task automatic check_len(input string tag, input int exp);
    while (len_q.size() > 0) chk(tag, len_q.pop_front(), exp);
  endtask

  initial begin
    int rd0;
    int budget;
    reset = 1'b0;

    // Outputs while held in reset
    tick(3);
    chk("rst_rdreq", bus.rdreq, 0);
    chk("rst_wr", bus.mem_wr_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_data", bus.mem_data_o, 0);
    reset = 1'b1;

    // Empty FIFO: nothing happens
    tick(20);
    chk("idle_rdreq_cnt", rd_cnt, 0);
    chk("idle_wr", bus.mem_wr_o, 0);
    chk("idle_addr", bus.mem_addr_o, 0);
    chk("idle_writes", obs_q.size(), 0);

    // Single pixel, ack tied high
    ack_tied = 1'b1;
    push_pix(5, 2, 24'h1E2E3E);
    wait_obs(1);
    chk("s2_addr", obs_q.size() > 0 ? 64'(obs_q[0][42:24]) : 64'hDEAD, 64'd1285);
    drain("s2");
    chk("s2_rdreq_cnt", rd_cnt, 1);
    check_len("s2_wr_len", 1);

    // Delayed ack: write held 6 cycles, no new read meanwhile
    ack_tied = 1'b0;
    ack_delay = 5;
    push_pix(5, 2, 24'h1E2E3E);
    push_pix(5, 2, 24'h1E2E3E);
    drain("s3");
    check_len("s3_wr_len", 6);
    chk("s3_rdreq_cnt", rd_cnt, 3);
    chk("s3_viol", viol, 0);

    // Out-of-range drop, then bottom-right corner
    ack_delay = 0;
    push_pix(700, 10, 24'hABCDEF);
    drain("s4_drop");
`ifdef PIXEL_DROP_CNT_EN
    chk("s4_drop_cnt", drop_cnt, 1);
`endif
    push_pix(639, 479, 24'h123456);
    wait_obs(1);
    chk("s4_corner", obs_q.size() > 0 ? 64'(obs_q[0][42:24]) : 64'hDEAD, 64'd307199);
    drain("s4");
    check_len("s4_wr_len", 1);

    // Three back-to-back words, continuous ack
    ack_tied = 1'b1;
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++)
      push_pix(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 24'($urandom));
    drain("s5");
    tick(20);
    chk("s5_rdreq_cnt", rd_cnt - rd0, 3);
    check_len("s5_wr_len", 1);

    // Random pixels, some off-screen, random ack latency
    ack_tied = 1'b0;
    ack_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_pix(int'($urandom_range(0, 719)), int'($urandom_range(0, 519)), 24'($urandom));
      if ($urandom_range(0, 2) == 0) tick(int'($urandom_range(1, 12)));
    end
    drain("rand");
    len_q.delete();
    ack_rand = 1'b0;

    // Reset during a pending write: word lost, next word still read
    ack_delay = 20;
    push_pix(100, 200, 24'hAA5511);
    push_pix(3, 4, 24'h0F0F0F);
    budget = 100;
    while (!bus.mem_wr_o && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("s6_wr_started", bus.mem_wr_o, 1);
    tick(2);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_async_wr", bus.mem_wr_o, 0);
    chk("s6_async_rdreq", bus.rdreq, 0);
    chk("s6_async_addr", bus.mem_addr_o, 0);
    chk("s6_async_data", bus.mem_data_o, 0);
    tick(2);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    ack_delay = 1;
    reset = 1'b1;
    drain("s6");
    check_len("s6_wr_len", 2);

`ifdef PIXEL_DROP_CNT_EN
    chk("final_drop_cnt", drop_cnt, exp_drop);
`endif
    chk("final_underflow", underflow, 0);
    chk("final_viol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
